// File: rtl/core_mem_arbiter.sv
// N-channel round-robin memory arbiter: one transaction in flight, responses routed to the owning channel.
// Define MEMARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins priority.
module core_mem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_cmd_start,
    input  logic [NUM_CH-1:0]        ch_cmd_write,
    output logic [NUM_CH-1:0]        ch_cmd_ready,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    input  logic [NUM_CH*DATA_W-1:0] ch_wmask,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_rdata_valid,
    output logic                     mem_cmd_start,
    output logic                     mem_cmd_write,
    input  logic                     mem_cmd_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [DATA_W-1:0]        mem_wmask,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_rdata_valid
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } state_t;

    state_t              state_q;
    logic [CH_W-1:0]     rr_ptr_q;
    logic [CH_W-1:0]     owner_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   wmask_q;
    logic                mem_start_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [NUM_CH-1:0]   rdata_valid_q;

    logic                gnt_vld_d;
    logic [CH_W-1:0]     gnt_idx_d;
    logic                sel_write_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [DATA_W-1:0]   sel_wdata_d;
    logic [DATA_W-1:0]   sel_wmask_d;

    // Descending scans leave the lowest matching index as the winner.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_idx_d = '0;
`ifdef MEMARB_FIXED_PRIORITY_EN
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_cmd_start[i]) begin
                gnt_vld_d = 1'b1;
                gnt_idx_d = CH_W'(i);
            end
        end
`else
        // Wrapped candidates (<= rr_ptr) first, then the ones after rr_ptr override them.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_cmd_start[i] && (CH_W'(i) <= rr_ptr_q)) begin
                gnt_vld_d = 1'b1;
                gnt_idx_d = CH_W'(i);
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_cmd_start[i] && (CH_W'(i) > rr_ptr_q)) begin
                gnt_vld_d = 1'b1;
                gnt_idx_d = CH_W'(i);
            end
        end
`endif
    end

    always_comb begin
        sel_write_d = 1'b0;
        sel_addr_d  = '0;
        sel_wdata_d = '0;
        sel_wmask_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == gnt_idx_d) begin
                sel_write_d = ch_cmd_write[i];
                sel_addr_d  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata_d = ch_wdata[i*DATA_W +: DATA_W];
                sel_wmask_d = ch_wmask[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ch_cmd_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((state_q == IDLE) && gnt_vld_d && (CH_W'(i) == gnt_idx_d)) begin
                ch_cmd_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= CH_W'(NUM_CH - 1);
            owner_q       <= '0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            mem_start_q   <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= '0;
        end else begin
            rdata_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        write_q     <= sel_write_d;
                        addr_q      <= sel_addr_d;
                        wdata_q     <= sel_wdata_d;
                        wmask_q     <= sel_wmask_d;
                        owner_q     <= gnt_idx_d;
                        rr_ptr_q    <= gnt_idx_d;
                        mem_start_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_cmd_ready) begin
                        mem_start_q <= 1'b0;
                        state_q     <= write_q ? IDLE : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (mem_rdata_valid) begin
                        rdata_q                <= mem_rdata;
                        rdata_valid_q[owner_q] <= 1'b1;
                        state_q                <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_cmd_start  = mem_start_q;
    assign mem_cmd_write  = write_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign ch_rdata       = rdata_q;
    assign ch_rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: a 2-channel instance plus a 4-channel instance for round-robin ordering.
module tb_core_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 2-channel instance
    logic [1:0]  a_start = '0, a_wr = '0, a_ready, a_rvalid_o;
    logic [63:0] a_addr = '0, a_wdata = '0, a_wmask = '0;
    logic [31:0] a_rdata_o, a_maddr, a_mwdata, a_mwmask;
    logic [31:0] a_mrdata = '0;
    logic        a_mstart, a_mwrite;
    logic        a_mready = 1'b0, a_mrvalid = 1'b0;

    core_mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) dut_a (
        .clk(clk), .reset(reset),
        .ch_cmd_start(a_start), .ch_cmd_write(a_wr), .ch_cmd_ready(a_ready),
        .ch_addr(a_addr), .ch_wdata(a_wdata), .ch_wmask(a_wmask),
        .ch_rdata(a_rdata_o), .ch_rdata_valid(a_rvalid_o),
        .mem_cmd_start(a_mstart), .mem_cmd_write(a_mwrite), .mem_cmd_ready(a_mready),
        .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_wmask(a_mwmask),
        .mem_rdata(a_mrdata), .mem_rdata_valid(a_mrvalid)
    );

    // 4-channel instance
    logic [3:0]  b_start = '0, b_wr = '0, b_ready, b_rvalid_o;
    logic [63:0] b_addr = '0, b_wdata = '0, b_wmask = '0;
    logic [15:0] b_rdata_o, b_maddr, b_mwdata, b_mwmask;
    logic [15:0] b_mrdata = '0;
    logic        b_mstart, b_mwrite;
    logic        b_mready = 1'b0, b_mrvalid = 1'b0;

    core_mem_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(16)) dut_b (
        .clk(clk), .reset(reset),
        .ch_cmd_start(b_start), .ch_cmd_write(b_wr), .ch_cmd_ready(b_ready),
        .ch_addr(b_addr), .ch_wdata(b_wdata), .ch_wmask(b_wmask),
        .ch_rdata(b_rdata_o), .ch_rdata_valid(b_rvalid_o),
        .mem_cmd_start(b_mstart), .mem_cmd_write(b_mwrite), .mem_cmd_ready(b_mready),
        .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_wmask(b_mwmask),
        .mem_rdata(b_mrdata), .mem_rdata_valid(b_mrvalid)
    );

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] data;
    } resp_t;

    resp_t resp_q[$];
    int    gnt_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops the next expected response once the 2-channel DUT pulses ch_rdata_valid.
    task automatic wait_resp(input int budget);
        resp_t e;
        int n = 0;
        while (a_rvalid_o == 2'b00 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (a_rvalid_o == 2'b00) begin
            checks++;
            errors++;
            $error("FAIL resp_timeout observed=none expected=pulse");
        end else if (resp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL resp_unexpected observed=%0h expected=none", a_rvalid_o);
        end else begin
            e = resp_q.pop_front();
            chk("resp_valid", 64'(a_rvalid_o), 64'(e.mask));
            chk("resp_data", 64'(a_rdata_o), 64'(e.data));
        end
    endtask

    // Called at a negedge while dut_a is in ISSUE; returns at the negedge showing the response pulse.
    task automatic serve_read(input logic [31:0] d);
        a_mready = 1'b1;
        @(negedge clk);
        a_mready  = 1'b0;
        a_mrvalid = 1'b1;
        a_mrdata  = d;
        @(negedge clk);
        a_mrvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        resp_t r;

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(a_ready), 64'(0));
        chk("rst_mem_start", 64'(a_mstart), 64'(0));
        chk("rst_rdata_valid", 64'(a_rvalid_o), 64'(0));
        chk("rst_rdata", 64'(a_rdata_o), 64'(0));
        chk("rst_mem_addr", 64'(a_maddr), 64'(0));
        reset = 1'b0;

        // 1: ch0 read 0x100
        @(negedge clk);
        a_start = 2'b01;
        a_wr    = 2'b00;
        a_addr[31:0] = 32'h100;
        #1 chk("t1_ready", 64'(a_ready), 64'(2'b01));
        @(negedge clk);
        a_start = 2'b00;
        chk("t1_mem_start", 64'(a_mstart), 64'(1));
        chk("t1_mem_addr", 64'(a_maddr), 64'(32'h100));
        chk("t1_mem_write", 64'(a_mwrite), 64'(0));
        chk("t1_ready_busy", 64'(a_ready), 64'(0));
        a_mready = 1'b1;
        r.mask = 2'b01; r.data = 32'hDEADBEEF;
        resp_q.push_back(r);
        @(negedge clk);
        a_mready = 1'b0;
        chk("t1_mem_start_drop", 64'(a_mstart), 64'(0));
        @(negedge clk);
        a_mrvalid = 1'b1;
        a_mrdata  = 32'hDEADBEEF;
        @(negedge clk);
        a_mrvalid = 1'b0;
        wait_resp(4);
        @(negedge clk);
        chk("t1_pulse_width", 64'(a_rvalid_o), 64'(0));
        chk("t1_rdata_hold", 64'(a_rdata_o), 64'(32'hDEADBEEF));

        // 2: both channels read continuously
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        a_start = 2'b11;
        a_wr    = 2'b00;
        a_addr  = {32'h20, 32'h10};
`ifdef MEMARB_FIXED_PRIORITY_EN
        gnt_q = '{0, 0, 0, 0};
`else
        gnt_q = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            g = gnt_q.pop_front();
            #1 chk("t2_grant", 64'(a_ready), 64'(1 << g));
            @(negedge clk);
            chk("t2_mem_addr", 64'(a_maddr), (g == 1) ? 64'h20 : 64'h10);
            r.mask = 2'(1 << g); r.data = 32'hA000 + 32'(i);
            resp_q.push_back(r);
            serve_read(32'hA000 + 32'(i));
            wait_resp(2);
        end
        a_start = 2'b00;
        @(negedge clk);

        // 3: ch1 write with downstream backpressure
        a_start = 2'b10;
        a_wr    = 2'b10;
        a_addr  = {32'h200, 32'h0};
        a_wdata = {32'h12345678, 32'h0};
        a_wmask = {32'hFFFFFFFF, 32'h0};
        #1 chk("t3_ready", 64'(a_ready), 64'(2'b10));
        @(negedge clk);
        a_start = 2'b00;
        a_wr    = 2'b00;
        a_addr  = '1;
        a_wdata = '0;
        a_wmask = '0;
        for (int k = 0; k < 4; k++) begin
            chk("t3_mem_start", 64'(a_mstart), 64'(1));
            chk("t3_mem_write", 64'(a_mwrite), 64'(1));
            chk("t3_mem_addr", 64'(a_maddr), 64'(32'h200));
            chk("t3_mem_wdata", 64'(a_mwdata), 64'(32'h12345678));
            chk("t3_mem_wmask", 64'(a_mwmask), 64'(32'hFFFFFFFF));
            if (k == 3) a_mready = 1'b1;
            @(negedge clk);
        end
        a_mready = 1'b0;
        chk("t3_idle_start", 64'(a_mstart), 64'(0));
        chk("t3_no_rvalid", 64'(a_rvalid_o), 64'(0));
        a_addr = '0;

        // 4: spurious read data in IDLE and in ISSUE
        a_mrvalid = 1'b1;
        a_mrdata  = 32'h55;
        @(negedge clk);
        a_mrvalid = 1'b0;
        chk("t4_idle_no_pulse", 64'(a_rvalid_o), 64'(0));
        chk("t4_idle_rdata", 64'(a_rdata_o), 64'(32'hA003));
        a_start = 2'b01;
        a_addr[31:0] = 32'h300;
        #1 chk("t4_ready", 64'(a_ready), 64'(2'b01));
        @(negedge clk);
        a_start   = 2'b00;
        a_mrvalid = 1'b1;
        a_mrdata  = 32'h66;
        @(negedge clk);
        a_mrvalid = 1'b0;
        chk("t4_issue_no_pulse", 64'(a_rvalid_o), 64'(0));
        chk("t4_issue_held", 64'(a_mstart), 64'(1));
        chk("t4_issue_addr", 64'(a_maddr), 64'(32'h300));
        r.mask = 2'b01; r.data = 32'h77;
        resp_q.push_back(r);
        serve_read(32'h77);
        wait_resp(2);

        // 5: reset while waiting for read data
        a_start = 2'b01;
        a_addr[31:0] = 32'h400;
        #1 chk("t5_ready", 64'(a_ready), 64'(2'b01));
        @(negedge clk);
        a_start  = 2'b00;
        a_mready = 1'b1;
        @(negedge clk);
        a_mready = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        a_mrvalid = 1'b1;
        a_mrdata  = 32'h99;
        @(negedge clk);
        a_mrvalid = 1'b0;
        chk("t5_no_pulse", 64'(a_rvalid_o), 64'(0));
        chk("t5_mem_start", 64'(a_mstart), 64'(0));
        chk("t5_mem_addr", 64'(a_maddr), 64'(0));
        chk("t5_rdata", 64'(a_rdata_o), 64'(0));
        chk("t5_ready_idle", 64'(a_ready), 64'(0));
        a_start = 2'b10;
        a_addr  = {32'h500, 32'h0};
        #1 chk("t5_next_ready", 64'(a_ready), 64'(2'b10));
        @(negedge clk);
        a_start = 2'b00;
        r.mask = 2'b10; r.data = 32'hCAFE;
        resp_q.push_back(r);
        serve_read(32'hCAFE);
        wait_resp(2);

        // 6: four channels, ch1 granted last, then ch1..3 contend
        b_start = 4'b0010;
        b_wr    = 4'b1110;
        #1 chk("t6_first", 64'(b_ready), 64'(4'b0010));
        @(negedge clk);
        b_start  = 4'b0000;
        b_mready = 1'b1;
        @(negedge clk);
        b_mready = 1'b0;
        b_start  = 4'b1110;
`ifdef MEMARB_FIXED_PRIORITY_EN
        gnt_q = '{1, 2, 3};
`else
        gnt_q = '{2, 3, 1};
`endif
        for (int i = 0; i < 3; i++) begin
            g = gnt_q.pop_front();
            #1 chk("t6_grant", 64'(b_ready), 64'(1 << g));
            @(negedge clk);
            b_start[g] = 1'b0;
            chk("t6_mem_start", 64'(b_mstart), 64'(1));
            chk("t6_mem_write", 64'(b_mwrite), 64'(1));
            b_mready = 1'b1;
            @(negedge clk);
            b_mready = 1'b0;
        end
        chk("t6_b_no_rvalid", 64'(b_rvalid_o), 64'(0));
        chk("t6_queue_drained", 64'(resp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
